// File: rtl/uart_prog_loader.sv
// Program loader: UART byte receiver plus opcode filter that fills program SPRAM.
// Opcodes are written sequentially, then the remainder is zero-filled.
module uart_prog_loader #(
   parameter int          CLK_HZ          = 12000000,
   parameter int          BAUD            = 115200,
   parameter int          PROG_ADDR_WIDTH = 14,
   parameter int          PROG_LEN        = 16383,
   parameter logic [7:0]  END_CHAR        = 8'h21
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       uart_rx,
   input  logic                       load_req,
   output logic                       prog_we,
   output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
   output logic [7:0]                 prog_wr,
   output logic                       loaded,
   output logic                       busy,
   output logic [PROG_ADDR_WIDTH-1:0] inst_count,
   output logic                       overflow,
   output logic                       frame_err
);

   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] C_HALF = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] C_FULL = CW'(DIV - 1);
   localparam logic [PROG_ADDR_WIDTH-1:0] A_LEN  = PROG_ADDR_WIDTH'(PROG_LEN);
   localparam logic [PROG_ADDR_WIDTH-1:0] A_LAST = PROG_ADDR_WIDTH'(PROG_LEN - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_FILL, S_DONE} state_t;

   logic r_rx_s1, r_rx_s2, r_rx_d;

   rx_state_t r_rx_state, w_rx_state_nxt;
   logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
   logic [2:0]    r_rx_bit, w_rx_bit_nxt;
   logic [7:0]    r_rx_sh,  w_rx_sh_nxt;
   logic          w_rx_valid, w_rx_ferr;

   state_t r_state, w_state_nxt;
   logic [PROG_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
   logic [PROG_ADDR_WIDTH-1:0] r_count, w_count_nxt;
   logic [7:0] r_wr, w_wr_nxt;
   logic r_loaded, w_loaded_nxt;
   logic r_busy, w_busy_nxt;
   logic r_ovf, w_ovf_nxt;
   logic r_ferr, w_ferr_nxt;
   logic w_is_op;

   // r_rx_d trails the synchronizer by one cycle for start-edge detection
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
         r_rx_d  <= 1'b1;
      end else begin
         r_rx_s1 <= uart_rx;
         r_rx_s2 <= r_rx_s1;
         r_rx_d  <= r_rx_s2;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_sh    <= '0;
      end else begin
         r_rx_state <= w_rx_state_nxt;
         r_rx_cnt   <= w_rx_cnt_nxt;
         r_rx_bit   <= w_rx_bit_nxt;
         r_rx_sh    <= w_rx_sh_nxt;
      end
   end

   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
      w_rx_bit_nxt   = r_rx_bit;
      w_rx_sh_nxt    = r_rx_sh;
      w_rx_valid     = 1'b0;
      w_rx_ferr      = 1'b0;
      unique case (r_rx_state)
         RX_IDLE: begin
            w_rx_cnt_nxt = '0;
            if (r_rx_d && !r_rx_s2) w_rx_state_nxt = RX_START;
         end
         RX_START: begin
            if (r_rx_cnt == C_HALF) begin
               w_rx_cnt_nxt   = '0;
               w_rx_bit_nxt   = '0;
               w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (r_rx_cnt == C_FULL) begin
               w_rx_cnt_nxt = '0;
               w_rx_sh_nxt  = {r_rx_s2, r_rx_sh[7:1]};
               w_rx_bit_nxt = r_rx_bit + 3'd1;
               if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
            end
         end
         RX_STOP: begin
            if (r_rx_cnt == C_FULL) begin
               w_rx_cnt_nxt   = '0;
               w_rx_state_nxt = RX_IDLE;
               w_rx_valid     = r_rx_s2;
               w_rx_ferr      = !r_rx_s2;
            end
         end
         default: w_rx_state_nxt = RX_IDLE;
      endcase
   end

   always_comb begin
      w_is_op = r_rx_sh inside {8'h3E, 8'h3C, 8'h2B, 8'h2D,
                                8'h2E, 8'h2C, 8'h5B, 8'h5D};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_count  <= '0;
         r_wr     <= '0;
         r_loaded <= 1'b0;
         r_busy   <= 1'b0;
         r_ovf    <= 1'b0;
         r_ferr   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_addr   <= w_addr_nxt;
         r_count  <= w_count_nxt;
         r_wr     <= w_wr_nxt;
         r_loaded <= w_loaded_nxt;
         r_busy   <= w_busy_nxt;
         r_ovf    <= w_ovf_nxt;
         r_ferr   <= w_ferr_nxt;
      end
   end

   // load_req wins over everything; a write already on the bus this cycle still lands
   always_comb begin
      w_state_nxt  = r_state;
      w_addr_nxt   = r_addr;
      w_count_nxt  = r_count;
      w_wr_nxt     = r_wr;
      w_loaded_nxt = r_loaded;
      w_busy_nxt   = r_busy;
      w_ovf_nxt    = r_ovf;
      if (load_req) begin
         w_state_nxt  = S_RECV;
         w_addr_nxt   = '0;
         w_count_nxt  = '0;
         w_loaded_nxt = 1'b0;
         w_busy_nxt   = 1'b1;
         w_ovf_nxt    = 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: ;
            S_RECV: begin
               if (w_rx_valid) begin
                  if (r_rx_sh == END_CHAR) begin
                     if (r_count < A_LEN) begin
                        w_state_nxt = S_FILL;
                        w_wr_nxt    = 8'h00;
                     end else begin
                        w_state_nxt  = S_DONE;
                        w_loaded_nxt = 1'b1;
                        w_busy_nxt   = 1'b0;
                        w_addr_nxt   = '0;
                     end
                  end else if (w_is_op) begin
                     if (r_count < A_LEN) begin
                        w_wr_nxt    = r_rx_sh;
                        w_state_nxt = S_WRITE;
                     end else begin
                        w_ovf_nxt = 1'b1;
                     end
                  end
               end
            end
            S_WRITE: begin
               w_state_nxt = S_RECV;
               w_count_nxt = r_count + 1'b1;
               if (r_addr < A_LAST) w_addr_nxt = r_addr + 1'b1;
            end
            S_FILL: begin
               if (r_addr == A_LAST) begin
                  w_state_nxt  = S_DONE;
                  w_loaded_nxt = 1'b1;
                  w_busy_nxt   = 1'b0;
                  w_addr_nxt   = '0;
               end else begin
                  w_addr_nxt = r_addr + 1'b1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
      w_ferr_nxt = (load_req ? 1'b0 : r_ferr) | w_rx_ferr;
   end

   assign prog_we    = (r_state == S_WRITE) || (r_state == S_FILL);
   assign prog_addr  = r_addr;
   assign prog_wr    = r_wr;
   assign loaded     = r_loaded;
   assign busy       = r_busy;
   assign inst_count = r_count;
   assign overflow   = r_ovf;
   assign frame_err  = r_ferr;

endmodule
